// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, constants and types for the St.PU register file.
// Optional feature macro used by this slice: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned RegNum     = 32;

    typedef logic [RegBus-1:0]     reg_word_t;
    typedef logic [RegAddrBus-1:0] reg_addr_t;
    typedef reg_word_t [RegNum-1:0] reg_array_t;

    localparam reg_word_t ZeroWord    = 32'h0000_0000;
    localparam logic      WriteEnable = 1'b1;
    localparam logic      ReadEnable  = 1'b1;
    localparam reg_addr_t NOPRegAddr  = 5'd0;

    // Register 0 is hardwired to zero, so both write and read paths test for it.
    function automatic logic is_zero_addr(input reg_addr_t addr);
        return (addr == NOPRegAddr);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// regfile_if: ID/WB-facing bus of the register file (one write port, two read ports).
// Optional feature macro affecting the slave side: REGFILE_BYPASS_EN.
interface regfile_if;
    import regfile_pkg::*;

    logic      we;
    reg_addr_t waddr;
    reg_word_t wdata;
    logic      re1;
    reg_addr_t raddr1;
    reg_word_t rdata1;
    logic      re2;
    reg_addr_t raddr2;
    reg_word_t rdata2;

    modport master (
        output we, waddr, wdata,
        output re1, raddr1,
        output re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1,
        input  re2, raddr2,
        output rdata1, rdata2
    );

endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: combinational read mux for one port.
// Priority: reset -> enable -> zero register -> bypass (REGFILE_BYPASS_EN only) -> storage.
module regfile_rd_port
    import regfile_pkg::*;
(
    input  logic       rst,
    input  logic       re,
    input  reg_addr_t  raddr,
    input  reg_array_t regs,
    output reg_word_t  rdata
`ifdef REGFILE_BYPASS_EN
    ,
    input  logic       we,
    input  reg_addr_t  waddr,
    input  reg_word_t  wdata
`endif
);

    // Select read data following the fixed priority order; every branch yields a defined value.
    always_comb begin
        rdata = ZeroWord;
        if (!rst) begin
            rdata = ZeroWord;
        end else if (re != ReadEnable) begin
            rdata = ZeroWord;
        end else if (is_zero_addr(raddr)) begin
            rdata = ZeroWord;
`ifdef REGFILE_BYPASS_EN
        end else if ((we == WriteEnable) && (waddr == raddr)) begin
            rdata = wdata;
`endif
        end else begin
            rdata = regs[raddr];
        end
    end

endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file, two combinational read ports,
// one write port committing on the rising edge. r0 reads as zero.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    regfile_if.slave   bus
);

    reg_array_t regs_q;
    reg_array_t regs_d;
    reg_word_t  rdata1_s;
    reg_word_t  rdata2_s;

    // Next-state of the storage array: apply the write-back write, keep r0 pinned at zero.
    always_comb begin
        regs_d = regs_q;
        if ((bus.we == WriteEnable) && !is_zero_addr(bus.waddr)) begin
            regs_d[bus.waddr] = bus.wdata;
        end else begin
            regs_d = regs_q;
        end
        regs_d[NOPRegAddr] = ZeroWord;
    end

    // Storage register: cleared asynchronously, so a write on an edge with rst low is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_rd_port u_rd_port1 (
        .rst   (rst),
        .re    (bus.re1),
        .raddr (bus.raddr1),
        .regs  (regs_q),
        .rdata (rdata1_s)
`ifdef REGFILE_BYPASS_EN
        ,
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata)
`endif
    );

    regfile_rd_port u_rd_port2 (
        .rst   (rst),
        .re    (bus.re2),
        .raddr (bus.raddr2),
        .regs  (regs_q),
        .rdata (rdata2_s)
`ifdef REGFILE_BYPASS_EN
        ,
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata)
`endif
    );

    assign bus.rdata1 = rdata1_s;
    assign bus.rdata2 = rdata2_s;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: self-checking bench for regfile against a plain array model of the registers.
// Honours REGFILE_BYPASS_EN for the same-cycle read-during-write expectations.
module tb_regfile;

    logic clk;
    logic rst;

    regfile_if bus ();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    logic [31:0] model [32];
    int n_checks;
    int n_fail;

    // Expected read value from the architectural rules, using the model of stored values.
    function automatic logic [31:0] exp_read(input logic r, input logic en, input logic [4:0] ra,
                                             input logic w, input logic [4:0] wa, input logic [31:0] wd);
        if (!r) return 32'h0;
        if (!en) return 32'h0;
        if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (w && (wa == ra)) return wd;
`endif
        return model[ra];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        bus.we = w; bus.waddr = wa; bus.wdata = wd;
        bus.re1 = e1; bus.raddr1 = a1;
        bus.re2 = e2; bus.raddr2 = a2;
    endtask

    // Advance through one rising edge (model commits the write), then return at the falling edge.
    task automatic step_edge();
        @(posedge clk);
        if (!rst) clear_model();
        else if (bus.we && (bus.waddr != 5'd0)) model[bus.waddr] = bus.wdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_model();
        drive(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b1, 5'd31);
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1: got %h expected %h", bus.rdata1, 32'h0); end
        n_checks++;
        if (bus.rdata2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2: got %h expected %h", bus.rdata2, 32'h0); end
        step_edge();
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_hold_rd1: got %h expected %h", bus.rdata1, 32'h0); end
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
            #1;
            n_checks++;
            if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_all_rd1[%0d]: got %h expected %h", i, bus.rdata1, 32'h0); end
            n_checks++;
            if (bus.rdata2 !== 32'h0) begin n_fail++; $display("FAIL reset_all_rd2[%0d]: got %h expected %h", 31 - i, bus.rdata2, 32'h0); end
            step_edge();
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        step_edge();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7);
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_read: got %h expected %h", bus.rdata1, 32'hDEAD_BEEF); end
        n_checks++;
        if (bus.rdata2 !== 32'h0) begin n_fail++; $display("FAIL read_disabled_rd2: got %h expected %h", bus.rdata2, 32'h0); end
        bus.re1 = 1'b0;
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL read_disabled_rd1: got %h expected %h", bus.rdata1, 32'h0); end
        step_edge();
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL zero_same_cycle: got %h expected %h", bus.rdata1, 32'h0); end
        step_edge();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL zero_rd1: got %h expected %h", bus.rdata1, 32'h0); end
        n_checks++;
        if (bus.rdata2 !== 32'h0) begin n_fail++; $display("FAIL zero_rd2: got %h expected %h", bus.rdata2, 32'h0); end
        step_edge();
    endtask

    task automatic test_read_during_write();
        logic [31:0] same_exp;
`ifdef REGFILE_BYPASS_EN
        same_exp = 32'hA5A5_A5A5;
`else
        same_exp = 32'h0000_0011;
`endif
        drive(1'b1, 5'd3, 32'h0000_0011, 1'b0, 5'd0, 1'b0, 5'd0);
        step_edge();
        drive(1'b1, 5'd3, 32'hA5A5_A5A5, 1'b1, 5'd3, 1'b1, 5'd3);
        #1;
        n_checks++;
        if (bus.rdata1 !== same_exp) begin n_fail++; $display("FAIL rdw_same_rd1: got %h expected %h", bus.rdata1, same_exp); end
        n_checks++;
        if (bus.rdata2 !== same_exp) begin n_fail++; $display("FAIL rdw_same_rd2: got %h expected %h", bus.rdata2, same_exp); end
        step_edge();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL rdw_next_rd1: got %h expected %h", bus.rdata1, 32'hA5A5_A5A5); end
        n_checks++;
        if (bus.rdata2 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL rdw_next_rd2: got %h expected %h", bus.rdata2, 32'hA5A5_A5A5); end
        step_edge();
    endtask

    task automatic test_independent_ports();
        drive(1'b1, 5'd1, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0);
        step_edge();
        drive(1'b1, 5'd2, 32'h0000_0002, 1'b0, 5'd0, 1'b0, 5'd0);
        step_edge();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd1);
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h2) begin n_fail++; $display("FAIL indep_rd1: got %h expected %h", bus.rdata1, 32'h2); end
        n_checks++;
        if (bus.rdata2 !== 32'h1) begin n_fail++; $display("FAIL indep_rd2: got %h expected %h", bus.rdata2, 32'h1); end
        #1 rst = 1'b0;
        clear_model();
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL pulse_low_rd1: got %h expected %h", bus.rdata1, 32'h0); end
        n_checks++;
        if (bus.rdata2 !== 32'h0) begin n_fail++; $display("FAIL pulse_low_rd2: got %h expected %h", bus.rdata2, 32'h0); end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL pulse_after_r2: got %h expected %h", bus.rdata1, 32'h0); end
        n_checks++;
        if (bus.rdata2 !== 32'h0) begin n_fail++; $display("FAIL pulse_after_r1: got %h expected %h", bus.rdata2, 32'h0); end
        step_edge();
    endtask

    task automatic test_random();
        logic        w, e1, e2;
        logic [4:0]  wa, a1, a2;
        logic [31:0] wd, x1, x2;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) != 0);
            if (!rst) clear_model();
            w  = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            e1 = ($urandom_range(0, 7) != 0);
            e2 = ($urandom_range(0, 7) != 0);
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(w, wa, wd, e1, a1, e2, a2);
            #1;
            x1 = exp_read(rst, e1, a1, w, wa, wd);
            x2 = exp_read(rst, e2, a2, w, wa, wd);
            n_checks++;
            if (bus.rdata1 !== x1) begin n_fail++; $display("FAIL rand_rd1[%0d] a=%0d: got %h expected %h", c, a1, bus.rdata1, x1); end
            n_checks++;
            if (bus.rdata2 !== x2) begin n_fail++; $display("FAIL rand_rd2[%0d] a=%0d: got %h expected %h", c, a2, bus.rdata2, x2); end
            step_edge();
        end
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clear_model();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        test_reset();
        test_write_read();
        test_zero_reg();
        test_read_during_write();
        test_independent_ports();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
